// File: rtl/sobel_pkg.sv
// Shared types, geometry constants and arithmetic helpers for the Sobel stage.
//   IMG_W/IMG_H : image geometry (pixels per line, lines per frame)
//   ADDR_W      : pixel address width
//   pixel_t     : 8-bit pixel, grad_t : 11-bit signed gradient, state_t : frame FSM
package sobel_pkg;

    localparam int unsigned IMG_W     = 32;
    localparam int unsigned IMG_H     = 32;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned SUM_W     = 10;
    localparam int unsigned GRAD_W    = 11;
    localparam int unsigned MAG_W     = 12;
    localparam int unsigned COL_W     = $clog2(IMG_W);
    localparam int unsigned ROW_W     = $clog2(IMG_H);
    localparam int unsigned LAST_ADDR = (IMG_H - 2) * IMG_W + (IMG_W - 2);

    typedef logic [PIX_W-1:0]         pixel_t;
    typedef logic signed [GRAD_W-1:0] grad_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Weighted 1-2-1 sum of three pixels, max 1020.
    function automatic logic [SUM_W-1:0] wsum(input pixel_t a, input pixel_t b, input pixel_t c);
        return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
    endfunction

    // Signed difference of two weighted sums, range +-1020.
    function automatic grad_t gdiff(input logic [SUM_W-1:0] pos, input logic [SUM_W-1:0] neg);
        return $signed({1'b0, pos}) - $signed({1'b0, neg});
    endfunction

    // Absolute value widened to the magnitude width.
    function automatic logic [MAG_W-1:0] gabs(input grad_t g);
        grad_t n;
        n = -g;
        return g[GRAD_W-1] ? MAG_W'($unsigned(n)) : MAG_W'($unsigned(g));
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of delay: DEPTH-deep pixel shift register.
//   clk, rst : clock, asynchronous active-high clear
//   i_shift  : advance the line by one pixel
//   i_din    : pixel entering the line
//   o_dout   : pixel that entered DEPTH shifts ago
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH = IMG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift,
    input  logic [PIX_W-1:0] i_din,
    output logic [PIX_W-1:0] o_dout
);

    pixel_t r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_shift) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/sobel_window.sv
// Streaming 3x3 Sobel stage: buffers two lines of raster-order pixels and emits
// |Gx|+|Gy| (saturated to 8 bits) with the centre address for each interior pixel.
// Build option: define SOBEL_THRESH_EN to binarise the magnitude against THRESH.
//   clk, rst   : clock, asynchronous active-high reset
//   sobel_en   : level enable; low returns to IDLE and clears frame state
//   pix_valid  : pix_in valid this cycle
//   pix_in     : pixel in raster order from address 0
//   out_valid  : one-cycle pulse per result
//   out_pix    : gradient magnitude or binarised value
//   out_addr   : centre pixel address of out_pix
//   done       : sticky frame-complete flag
module sobel_window
    import sobel_pkg::*;
#(
    parameter int unsigned THRESH = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sobel_en,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_in,
    output logic              out_valid,
    output logic [PIX_W-1:0]  out_pix,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done
);

    // Elaboration guard on geometry and threshold range.
    if ((IMG_W * IMG_H) > (2 ** ADDR_W) || THRESH >= (2 ** MAG_W)) begin : g_bad_param
        $error("sobel_window: invalid geometry or THRESH");
    end

    state_t            r_state;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    pixel_t            r_win [3][3];
    logic              r_win_valid;
    logic [ADDR_W-1:0] r_win_addr;

    logic              w_accept;
    logic              w_last_col;
    logic              w_last_row;
    logic              w_win_ok;
    logic [ADDR_W-1:0] w_centre_addr;
    pixel_t            w_lb0_out;
    pixel_t            w_lb1_out;
    logic [SUM_W-1:0]  w_gx_pos;
    logic [SUM_W-1:0]  w_gx_neg;
    logic [SUM_W-1:0]  w_gy_pos;
    logic [SUM_W-1:0]  w_gy_neg;
    grad_t             w_gx;
    grad_t             w_gy;
    logic [MAG_W-1:0]  w_mag;
    pixel_t            w_result;

    assign w_accept   = sobel_en && (r_state == RUN) && pix_valid;
    assign w_last_col = (r_col == COL_W'(IMG_W - 1));
    assign w_last_row = (r_row == ROW_W'(IMG_H - 1));
    // Window columns col-2..col all belong to rows row-2..row only from (2,2) on.
    assign w_win_ok   = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    assign w_centre_addr = ADDR_W'((int'(r_row) - 1) * int'(IMG_W) + int'(r_col) - 1);

    // lb0 delays by one line, lb1 by two lines.
    sobel_line_buffer #(.DEPTH(IMG_W)) u_lb0 (
        .clk     (clk),
        .rst     (rst),
        .i_shift (w_accept),
        .i_din   (pix_in),
        .o_dout  (w_lb0_out)
    );

    sobel_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
        .clk     (clk),
        .rst     (rst),
        .i_shift (w_accept),
        .i_din   (w_lb0_out),
        .o_dout  (w_lb1_out)
    );

    // Gradient on the registered window.
    assign w_gx_pos = wsum(r_win[0][2], r_win[1][2], r_win[2][2]);
    assign w_gx_neg = wsum(r_win[0][0], r_win[1][0], r_win[2][0]);
    assign w_gy_pos = wsum(r_win[2][0], r_win[2][1], r_win[2][2]);
    assign w_gy_neg = wsum(r_win[0][0], r_win[0][1], r_win[0][2]);
    assign w_gx     = gdiff(w_gx_pos, w_gx_neg);
    assign w_gy     = gdiff(w_gy_pos, w_gy_neg);
    assign w_mag    = gabs(w_gx) + gabs(w_gy);

    always_comb begin
        w_result = '0;
`ifdef SOBEL_THRESH_EN
        w_result = (w_mag >= MAG_W'(THRESH)) ? 8'hFF : 8'h00;
`else
        w_result = (w_mag > MAG_W'(255)) ? 8'hFF : w_mag[7:0];
`endif
    end

    // Frame FSM, counters, window and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_win_valid <= 1'b0;
            r_win_addr  <= '0;
            out_valid   <= 1'b0;
            out_pix     <= '0;
            out_addr    <= '0;
            done        <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (!sobel_en) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_win_valid <= 1'b0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
        end else begin
            out_valid   <= r_win_valid;
            r_win_valid <= w_accept && w_win_ok;

            if (r_win_valid) begin
                out_pix  <= w_result;
                out_addr <= r_win_addr;
            end

            if (w_accept) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb1_out;
                r_win[1][2] <= w_lb0_out;
                r_win[2][2] <= pix_in;
                r_win_addr  <= w_centre_addr;

                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end

            case (r_state)
                IDLE: r_state <= RUN;
                RUN: begin
                    // Leave RUN on the edge that registers the final result.
                    if (r_win_valid && (r_win_addr == ADDR_W'(LAST_ADDR))) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                    end
                end
                DONE:    r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_window.sv
module tb_sobel_window;
    import sobel_pkg::*;

    localparam int N_RES     = 900;
    localparam int THRESH_TB = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              sobel_en;
    logic              pix_valid;
    logic [7:0]        pix_in;
    logic              out_valid;
    logic [7:0]        out_pix;
    logic [ADDR_W-1:0] out_addr;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;
    int pattern  = 0;
    int cur_idx  = -1;
    bit check_lat = 1'b0;

    always #5 clk = ~clk;

    sobel_window #(.THRESH(THRESH_TB)) dut (
        .clk       (clk),
        .rst       (rst),
        .sobel_en  (sobel_en),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .out_valid (out_valid),
        .out_pix   (out_pix),
        .out_addr  (out_addr),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pixval(input int pat, input int idx);
        int col;
        col = idx % 32;
        case (pat)
            0:       return 8'h80;
            1:       return (col < 16) ? 8'h00 : 8'hFF;
            default: return 8'(col * 8);
        endcase
    endfunction

    function automatic logic [31:0] exp_addr(input int idx);
        return 32'((idx / 30 + 1) * 32 + (idx % 30 + 1));
    endfunction

    function automatic logic [31:0] exp_pix(input int pat, input int idx);
        int c;
        int mag;
        c = idx % 30 + 1;
        case (pat)
            0:       mag = 0;
            1:       mag = (c == 15 || c == 16) ? 1020 : 0;
            default: mag = 64;
        endcase
`ifdef SOBEL_THRESH_EN
        return (mag >= THRESH_TB) ? 32'hFF : 32'h00;
`else
        return (mag > 255) ? 32'hFF : 32'(mag);
`endif
    endfunction

    // One clock: drive inputs, then score whatever result appears after the edge.
    task automatic step(input logic v, input logic [7:0] p);
        pix_valid = v;
        pix_in    = p;
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) begin
            if (k >= N_RES) begin
                chk("extra_result", 32'(out_valid), 32'd0);
            end else begin
                if (k == 0 && check_lat) chk("first_latency_idx", 32'(cur_idx), 32'd67);
                chk("addr", 32'(out_addr), exp_addr(k));
                chk("pix", 32'(out_pix), exp_pix(pattern, k));
                chk("done_edge", 32'(done), (k == N_RES - 1) ? 32'd1 : 32'd0);
                k++;
            end
        end
    endtask

    task automatic run_frame(input int pat, input bit gapped, input int npix);
        pattern   = pat;
        k         = 0;
        check_lat = !gapped;
        sobel_en  = 1'b1;
        cur_idx   = -1;
        step(1'b0, 8'h00);
        for (int i = 0; i < npix; i++) begin
            if (gapped) begin
                for (int g = 0; g < 4 && $urandom_range(0, 1) == 0; g++) begin
                    cur_idx = -1;
                    step(1'b0, 8'($urandom));
                end
            end
            cur_idx = i;
            step(1'b1, pixval(pat, i));
        end
        cur_idx = -1;
        if (npix == 1024) begin
            repeat (3) step(1'b0, 8'h00);
            chk("result_count", 32'(k), 32'(N_RES));
            chk("done_final", 32'(done), 32'd1);
        end
    endtask

    task automatic drop_en(input string tag);
        sobel_en = 1'b0;
        step(1'b0, 8'h00);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic reset_pulse(input string tag);
        #2;
        rst = 1'b1;
        #1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_pix"}, 32'(out_pix), 32'd0);
        chk({tag, "_addr"}, 32'(out_addr), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_state"}, 32'(dut.r_state), 32'(IDLE));
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        sobel_en  = 1'b0;
        pix_valid = 1'b0;
        pix_in    = 8'h00;

        // Power-on reset asserted mid-cycle, idle afterwards.
        @(posedge clk);
        #1;
        reset_pulse("por");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h80);
            chk("idle_no_valid", 32'(out_valid), 32'd0);
        end

        // Flat frame, continuous input.
        run_frame(0, 1'b0, 1024);

        // Pixels offered while DONE are ignored.
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 8'h80);
            chk("postdone_valid", 32'(out_valid), 32'd0);
            chk("postdone_done", 32'(done), 32'd1);
        end
        drop_en("postdone_drop");

        // Vertical edge between columns 15 and 16.
        run_frame(1, 1'b0, 1024);
        drop_en("vedge_drop");

        // Horizontal ramp with random input gaps.
        run_frame(2, 1'b1, 1024);
        drop_en("ramp_drop");

        // Abort by reset after pixel 500, then a clean frame.
        run_frame(0, 1'b0, 501);
        reset_pulse("abort_rst");
        run_frame(0, 1'b0, 1024);
        drop_en("after_rst_drop");

        // Abort by a one-cycle enable drop, then a clean frame.
        run_frame(0, 1'b0, 501);
        drop_en("abort_en");
        run_frame(0, 1'b0, 1024);
        drop_en("final_drop");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
